// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state, opcode, funct and ALU encodings shared by the multicycle controller
package mips_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    function automatic logic funct_ok(input logic [5:0] f);
        return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
    endfunction
endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: maps (aluop, funct) to alucontrol; ports aluop/funct in, alucontrol out
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  aluop_t      aluop,
    input  logic [5:0]  funct,
    output logic [2:0]  alucontrol
);
    always_comb begin
        alucontrol = aluop == ALUOP_SUB   ? ALU_SUB :
                     aluop != ALUOP_FUNCT ? ALU_ADD :
                     funct == FN_SUB      ? ALU_SUB :
                     funct == FN_AND      ? ALU_AND :
                     funct == FN_OR       ? ALU_OR  :
                     funct == FN_SLT      ? ALU_SLT : ALU_ADD;
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore FSM sequencing the multicycle MIPS datapath; inputs op/funct/zero/mem_ready, outputs datapath selects, enables, memory handshake, illegal_op and state_dbg
module multicycle_controller
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        iord,
    output logic        memwrite,
    output logic        irwrite,
    output logic        pcen,
    output logic        regwrite,
    output logic        regdst,
    output logic        memtoreg,
    output logic        alusrca,
    output logic [1:0]  alusrcb,
    output logic [1:0]  pcsrc,
    output logic [2:0]  alucontrol,
    output logic        illegal_op,
    output logic [3:0]  state_dbg
);
    logic [3:0] state, nxt;
    logic       pcwrite, branch, legal;
    aluop_t     aluop;

    assign legal = op inside {OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J} || (op == OP_RTYPE && funct_ok(funct));

    always_ff @(posedge clk)
        state <= reset ? S_FETCH : nxt;

    always_comb begin
        nxt        = S_FETCH;
        mem_req    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        illegal_op = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                nxt     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                alusrcb    = 2'b11;
                illegal_op = ~legal;
                nxt        = (op == OP_LW || op == OP_SW)           ? S_MEMADR  :
                             (op == OP_RTYPE && funct_ok(funct))    ? S_EXECUTE :
                             op == OP_BEQ                           ? S_BRANCH  :
                             op == OP_ADDI                          ? S_ADDIEX  :
                             op == OP_J                             ? S_JUMP    : S_FETCH;
            end
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = op == OP_LW ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                nxt     = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            S_MEMWR: begin
                mem_req  = 1'b1;
                iord     = 1'b1;
                memwrite = 1'b1;
                nxt      = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
                nxt     = S_ALUWB;
            end
            S_ALUWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            S_BRANCH: begin
                alusrca = 1'b1;
                aluop   = ALUOP_SUB;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = S_ADDIWB;
            end
            S_ADDIWB: regwrite = 1'b1;
            S_JUMP: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
    end

    assign pcen      = pcwrite | (branch & zero);
    assign state_dbg = state;

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: table-driven, directed and randomized checks of multicycle_controller against a phase-list model
module tb_multicycle_controller;
    import mips_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset, zero, mem_ready;
    logic [5:0]  op, funct;
    logic        mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca, illegal_op;
    logic [1:0]  alusrcb, pcsrc;
    logic [2:0]  alucontrol;
    logic [3:0]  state_dbg;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen),
        .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal_op(illegal_op),
        .state_dbg(state_dbg)
    );

    typedef struct packed {
        logic       mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic [2:0] alucontrol;
        logic       illegal_op;
        logic [3:0] state;
    } ctrl_t;

    typedef logic [3:0] ph_q_t[$];

    typedef struct {
        string      name;
        logic [5:0] op, funct;
        logic       zero;
        int         regw, memw, ill, pcn, cpi;
    } vec_t;

    ctrl_t act;
    assign act = {mem_req, iord, memwrite, irwrite, pcen, regwrite, regdst, memtoreg, alusrca,
                  alusrcb, pcsrc, alucontrol, illegal_op, state_dbg};

    int checks = 0, errors = 0;
    int n_regw, n_memw, n_ill, n_pcn, n_busy;

    function automatic bit legal(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'h23, 6'h2b, 6'h04, 6'h08, 6'h02: return 1'b1;
            6'h00: return f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h2a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    // Steps an instruction passes through, independent of stalls.
    function automatic ph_q_t phases(input logic [5:0] o, input logic [5:0] f);
        ph_q_t q;
        q.push_back(S_FETCH);
        q.push_back(S_DECODE);
        if (legal(o, f))
            case (o)
                6'h23: begin q.push_back(S_MEMADR); q.push_back(S_MEMRD); q.push_back(S_MEMWB); end
                6'h2b: begin q.push_back(S_MEMADR); q.push_back(S_MEMWR); end
                6'h00: begin q.push_back(S_EXECUTE); q.push_back(S_ALUWB); end
                6'h04: q.push_back(S_BRANCH);
                6'h08: begin q.push_back(S_ADDIEX); q.push_back(S_ADDIWB); end
                default: q.push_back(S_JUMP);
            endcase
        return q;
    endfunction

    function automatic ctrl_t model(input logic [3:0] ph, input logic [5:0] o, input logic [5:0] f,
                                    input logic z, input logic mr);
        ctrl_t c;
        c = '0;
        c.state = ph;
        c.alucontrol = 3'b010;
        case (ph)
            S_FETCH:   begin c.mem_req = 1; c.alusrcb = 2'b01; c.irwrite = mr; c.pcen = mr; end
            S_DECODE:  begin c.alusrcb = 2'b11; c.illegal_op = !legal(o, f); end
            S_MEMADR:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            S_MEMRD:   begin c.mem_req = 1; c.iord = 1; end
            S_MEMWB:   begin c.memtoreg = 1; c.regwrite = 1; end
            S_MEMWR:   begin c.mem_req = 1; c.iord = 1; c.memwrite = 1; end
            S_EXECUTE: begin c.alusrca = 1; c.alucontrol = funct_alu(f); end
            S_ALUWB:   begin c.regdst = 1; c.regwrite = 1; end
            S_BRANCH:  begin c.alusrca = 1; c.alucontrol = 3'b110; c.pcsrc = 2'b01; c.pcen = z; end
            S_ADDIEX:  begin c.alusrca = 1; c.alusrcb = 2'b10; end
            S_ADDIWB:  c.regwrite = 1;
            default:   begin c.pcsrc = 2'b10; c.pcen = 1; end
        endcase
        return c;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // One clock: drive mem_ready, compare every output mid-cycle, advance to just past the edge.
    task automatic step(input logic [3:0] ph, input logic mr, input string tag);
        ctrl_t e;
        mem_ready = mr;
        e = model(ph, op, funct, zero, mr);
        @(negedge clk);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s phase %0d: got %h expected %h", tag, ph, act, e);
        end
        n_regw += int'(act.regwrite);
        n_memw += int'(act.memwrite);
        n_ill  += int'(act.illegal_op);
        n_pcn  += int'(act.pcen);
        n_busy += int'(act.state != S_FETCH);
        @(posedge clk);
        #1;
    endtask

    // Stall counts < 0 are drawn at random per memory phase.
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f, input logic z,
                             input int fs, input int ms);
        ph_q_t q;
        int n;
        op = o; funct = f; zero = z;
        n_regw = 0; n_memw = 0; n_ill = 0; n_pcn = 0; n_busy = 0;
        q = phases(o, f);
        foreach (q[i]) begin
            if (q[i] inside {S_FETCH, S_MEMRD, S_MEMWR}) begin
                n = q[i] == S_FETCH ? fs : ms;
                if (n < 0) n = int'($urandom_range(0, 2));
                repeat (n) step(q[i], 1'b0, tag);
                step(q[i], 1'b1, tag);
            end else
                step(q[i], 1'($urandom_range(0, 1)), tag);
        end
    endtask

    vec_t vecs[$];
    logic [5:0] ops[7];
    logic [5:0] fns[6];

    initial begin
        vecs.push_back('{"lw",      6'h23, 6'h00, 1'b0, 1, 0, 0, 1, 5});
        vecs.push_back('{"sw",      6'h2b, 6'h00, 1'b0, 0, 1, 0, 1, 4});
        vecs.push_back('{"add",     6'h00, 6'h20, 1'b0, 1, 0, 0, 1, 4});
        vecs.push_back('{"slt",     6'h00, 6'h2a, 1'b0, 1, 0, 0, 1, 4});
        vecs.push_back('{"beq_z1",  6'h04, 6'h00, 1'b1, 0, 0, 0, 2, 3});
        vecs.push_back('{"beq_z0",  6'h04, 6'h00, 1'b0, 0, 0, 0, 1, 3});
        vecs.push_back('{"addi",    6'h08, 6'h00, 1'b0, 1, 0, 0, 1, 4});
        vecs.push_back('{"j",       6'h02, 6'h00, 1'b0, 0, 0, 0, 2, 3});
        vecs.push_back('{"bad_op",  6'h3f, 6'h20, 1'b0, 0, 0, 1, 1, 2});
        vecs.push_back('{"bad_fn",  6'h00, 6'h00, 1'b0, 0, 0, 1, 1, 2});

        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0; op = 6'h00; funct = 6'h20;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", int'(state_dbg), int'(S_FETCH));
        reset = 1'b0;

        // Reset in the middle of a stalled store.
        op = 6'h2b; funct = 6'h00;
        step(S_FETCH, 1'b1, "pre_rst");
        step(S_DECODE, 1'b1, "pre_rst");
        step(S_MEMADR, 1'b1, "pre_rst");
        step(S_MEMWR, 1'b0, "pre_rst");
        reset = 1'b1;
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_state", int'(state_dbg), int'(S_FETCH));
            chk("rst_memwrite", int'(memwrite), 0);
        end
        reset = 1'b0;
        run_instr("post_rst_sw", 6'h2b, 6'h00, 1'b0, 0, 0);

        foreach (vecs[k]) begin
            run_instr(vecs[k].name, vecs[k].op, vecs[k].funct, vecs[k].zero, 0, 0);
            chk({vecs[k].name, "_regwrite"}, n_regw, vecs[k].regw);
            chk({vecs[k].name, "_memwrite"}, n_memw, vecs[k].memw);
            chk({vecs[k].name, "_illegal"},  n_ill,  vecs[k].ill);
            chk({vecs[k].name, "_pcen"},     n_pcn,  vecs[k].pcn);
            chk({vecs[k].name, "_cpi"},      n_busy + 1, vecs[k].cpi);
        end

        run_instr("sw_stall", 6'h2b, 6'h00, 1'b0, 2, 2);
        chk("sw_stall_memwrite", n_memw, 3);
        chk("sw_stall_pcen", n_pcn, 1);
        run_instr("lw_stall", 6'h23, 6'h00, 1'b0, 1, 2);
        chk("lw_stall_busy", n_busy, 4 + 2);

        ops = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h02, 6'h3f};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00};
        for (int r = 0; r < 200; r++) begin
            logic [5:0] o, f;
            o = ops[$urandom_range(0, 6)];
            if ($urandom_range(0, 7) == 0) o = 6'($urandom);
            f = fns[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) f = 6'($urandom);
            run_instr("random", o, f, 1'($urandom_range(0, 1)), -1, -1);
            chk("random_illegal", n_ill, legal(o, f) ? 0 : 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
